// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the 6502 system bus controller.
package sys_bus_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam int WAIT_W = 4;

    // Apple-1 memory map: slave i matches when (addr & MASK) == BASE
    localparam logic [15:0] RAM_BASE   = 16'h0000;
    localparam logic [15:0] RAM_MASK   = 16'hE000;
    localparam logic [15:0] UART_BASE  = 16'hD010;
    localparam logic [15:0] UART_MASK  = 16'hFFFC;
    localparam logic [15:0] BASIC_BASE = 16'hE000;
    localparam logic [15:0] BASIC_MASK = 16'hF000;
    localparam logic [15:0] WOZ_BASE   = 16'hFF00;
    localparam logic [15:0] WOZ_MASK   = 16'hFF00;

    // Flat tables, slave 0 in the least significant 16 bits
    localparam logic [63:0] SLV_BASE_DEF = {WOZ_BASE, BASIC_BASE, UART_BASE, RAM_BASE};
    localparam logic [63:0] SLV_MASK_DEF = {WOZ_MASK, BASIC_MASK, UART_MASK, RAM_MASK};

endpackage

// File: rtl/sys_bus_ctrl_clken_gen.sv
// CPU clock-enable generator: free-running divider with a registered tick pulse.
module clken_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Divider wraps at CLK_DIV-1; tick fires one cycle after the count passes zero
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = (cnt_q == {CW{1'b0}});
        if (cnt_q == CW'(CLK_DIV - 1)) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider and tick registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {CW{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/sys_bus_ctrl.sv
// 6502 CPU-side bus controller: reset sequencing, bus latching, table decode,
// read mux, per-slave wait states and write protection.
module sys_bus_ctrl
    import sys_bus_pkg::*;
#(
    parameter int                     CLK_DIV   = 25,
    parameter int                     RST_TICKS = 63,
    parameter int                     NUM_SLV   = 4,
    parameter logic [NUM_SLV*16-1:0]  SLV_BASE  = SLV_BASE_DEF,
    parameter logic [NUM_SLV*16-1:0]  SLV_MASK  = SLV_MASK_DEF,
    parameter logic [NUM_SLV*4-1:0]   SLV_WAIT  = {NUM_SLV*4{1'b0}},
    parameter logic [NUM_SLV-1:0]     SLV_RO    = {NUM_SLV{1'b0}},
    parameter logic [7:0]             OPEN_BUS  = 8'hFF
) (
    input  logic                   clk25,
    input  logic                   rst_n,
    input  logic [15:0]            cpu_ab,
    input  logic [7:0]             cpu_do,
    input  logic                   cpu_we,
    output logic                   cpu_rdy,
    output logic                   cpu_reset,
    output logic [7:0]             cpu_di,
    output logic [15:0]            bus_ab,
    output logic [7:0]             bus_do,
    output logic [NUM_SLV-1:0]     bus_we,
    output logic [NUM_SLV-1:0]     slv_cs,
    output logic                   slv_en,
    input  logic [NUM_SLV*8-1:0]   slv_dout,
    output logic                   bus_err
);

    state_e              state_q, state_d;
    logic [7:0]          rst_cnt_q, rst_cnt_d;
    logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
    logic [15:0]         bus_ab_q, bus_ab_d;
    logic [7:0]          bus_do_q, bus_do_d;
    logic                we_q, we_d;
    logic [7:0]          cpu_di_q, cpu_di_d;

    logic                tick_s;
    logic [NUM_SLV-1:0]  new_sel_s;
    logic [WAIT_W-1:0]   new_wait_s;
    logic [NUM_SLV-1:0]  slv_cs_s;
    logic [7:0]          rd_data_s;
    logic                ro_hit_s;

    // Table decode; scanning high to low lets the lowest matching index win
    function automatic logic [NUM_SLV-1:0] decode(input logic [15:0] addr);
        logic [NUM_SLV-1:0] hit;
        hit = {NUM_SLV{1'b0}};
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*16 +: 16]) == SLV_BASE[i*16 +: 16]) begin
                hit    = {NUM_SLV{1'b0}};
                hit[i] = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    clken_gen #(.CLK_DIV(CLK_DIV)) u_clken (
        .clk   (clk25),
        .rst_n (rst_n),
        .tick  (tick_s)
    );

    // Decode the latched bus (idle while in reset) and the incoming CPU address
    always_comb begin
        new_sel_s  = decode(cpu_ab);
        slv_cs_s   = (state_q == ST_RESET) ? {NUM_SLV{1'b0}} : decode(bus_ab_q);
        new_wait_s = {WAIT_W{1'b0}};
        rd_data_s  = 8'h00;
        for (int i = 0; i < NUM_SLV; i++) begin
            new_wait_s = new_wait_s | (SLV_WAIT[i*4 +: 4] & {WAIT_W{new_sel_s[i]}});
            rd_data_s  = rd_data_s | (slv_dout[i*8 +: 8] & {8{slv_cs_s[i]}});
        end
        ro_hit_s = |(slv_cs_s & SLV_RO);
    end

    // Next-state logic: reset sequencing, bus latching and wait counting
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        wcnt_d    = wcnt_q;
        bus_ab_d  = bus_ab_q;
        bus_do_d  = bus_do_q;
        we_d      = we_q;
        cpu_di_d  = cpu_di_q;
        if (tick_s) begin
            cpu_di_d = (|slv_cs_s) ? rd_data_s : OPEN_BUS;
        end else begin
            cpu_di_d = cpu_di_q;
        end
        case (state_q)
            ST_RESET: begin
                if (tick_s) begin
                    if (rst_cnt_q == 8'(RST_TICKS - 1)) begin
                        rst_cnt_d = 8'd0;
                        state_d   = ST_RUN;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 8'd1;
                    end
                end else begin
                    state_d = ST_RESET;
                end
            end
            ST_RUN: begin
                if (tick_s) begin
                    bus_ab_d = cpu_ab;
                    bus_do_d = cpu_do;
                    we_d     = cpu_we;
                    if (new_wait_s != {WAIT_W{1'b0}}) begin
                        wcnt_d  = new_wait_s;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (tick_s) begin
                    wcnt_d = wcnt_q - WAIT_W'(1);
                    if (wcnt_q == WAIT_W'(1)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: counters, latched bus and CPU read data
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt_q <= 8'd0;
            wcnt_q    <= {WAIT_W{1'b0}};
            bus_ab_q  <= 16'h0000;
            bus_do_q  <= 8'h00;
            we_q      <= 1'b0;
            cpu_di_q  <= OPEN_BUS;
        end else begin
            rst_cnt_q <= rst_cnt_d;
            wcnt_q    <= wcnt_d;
            bus_ab_q  <= bus_ab_d;
            bus_do_q  <= bus_do_d;
            we_q      <= we_d;
            cpu_di_q  <= cpu_di_d;
        end
    end

    // Output decode: RDY gating, access strobe and error pulse per state
    always_comb begin
        cpu_reset = 1'b0;
        cpu_rdy   = 1'b0;
        slv_en    = 1'b0;
        bus_err   = 1'b0;
        case (state_q)
            ST_RESET: begin
                cpu_reset = 1'b1;
                cpu_rdy   = tick_s;
            end
            ST_RUN: begin
                cpu_rdy = tick_s;
                slv_en  = tick_s & (|slv_cs_s);
                bus_err = tick_s & ((slv_cs_s == {NUM_SLV{1'b0}}) | (we_q & ro_hit_s));
            end
            ST_WAIT: begin
                cpu_rdy = 1'b0;
            end
            default: begin
                cpu_reset = 1'b1;
            end
        endcase
    end

    assign bus_we = slv_cs_s & ~SLV_RO & {NUM_SLV{we_q}};
    assign slv_cs = slv_cs_s;
    assign bus_ab = bus_ab_q;
    assign bus_do = bus_do_q;
    assign cpu_di = cpu_di_q;

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Self-checking bench for sys_bus_ctrl against an address-range reference model.
module tb_sys_bus_ctrl;

    localparam int CLK_DIV   = 25;
    localparam int RST_TICKS = 63;

    logic        clk25 = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic        cpu_rdy, cpu_reset;
    logic [7:0]  cpu_di;
    logic [15:0] bus_ab;
    logic [7:0]  bus_do;
    logic [3:0]  bus_we, slv_cs;
    logic        slv_en, bus_err;
    logic [31:0] slv_dout;

    int checks = 0;
    int errors = 0;

    // Reference: slave 3 has 2 wait ticks, slave 2 one; slaves 2 and 3 are read-only
    int ref_wait [4] = '{0, 0, 1, 2};
    int ref_ro   [4] = '{0, 0, 1, 1};

    logic [15:0] prev_a;
    logic        prev_w;
    logic [7:0]  prev_d;

    sys_bus_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .RST_TICKS (RST_TICKS),
        .NUM_SLV   (4),
        .SLV_WAIT  (16'h2100),
        .SLV_RO    (4'b1100),
        .OPEN_BUS  (8'hFF)
    ) dut (
        .clk25     (clk25),
        .rst_n     (rst_n),
        .cpu_ab    (cpu_ab),
        .cpu_do    (cpu_do),
        .cpu_we    (cpu_we),
        .cpu_rdy   (cpu_rdy),
        .cpu_reset (cpu_reset),
        .cpu_di    (cpu_di),
        .bus_ab    (bus_ab),
        .bus_do    (bus_do),
        .bus_we    (bus_we),
        .slv_cs    (slv_cs),
        .slv_en    (slv_en),
        .slv_dout  (slv_dout),
        .bus_err   (bus_err)
    );

    always #5 clk25 = ~clk25;

    // Apple-1 map written as plain address ranges
    function automatic int ref_slave(input logic [15:0] a);
        if (a <= 16'h1FFF) return 0;
        else if (a >= 16'hD010 && a <= 16'hD013) return 1;
        else if (a >= 16'hE000 && a <= 16'hEFFF) return 2;
        else if (a >= 16'hFF00) return 3;
        else return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_cpu_rdy",   32'(cpu_rdy),   32'd0);
        chk("rst_cpu_di",    32'(cpu_di),    32'hFF);
        chk("rst_bus_ab",    32'(bus_ab),    32'd0);
        chk("rst_bus_do",    32'(bus_do),    32'd0);
        chk("rst_bus_we",    32'(bus_we),    32'd0);
        chk("rst_slv_cs",    32'(slv_cs),    32'd0);
        chk("rst_slv_en",    32'(slv_en),    32'd0);
        chk("rst_bus_err",   32'(bus_err),   32'd0);
    endtask

    // Release reset, count ticks while cpu_reset is high, then align to the next tick
    task automatic reset_release_and_sync();
        int cyc, last, n_rst, bad_gap, first;
        cyc = 0; last = 0; n_rst = 0; bad_gap = 0; first = -1;
        @(negedge clk25);
        rst_n = 1'b1;
        while (cyc < 3000) begin
            @(negedge clk25);
            cyc++;
            if (cpu_rdy) begin
                if (first < 0) first = cyc;
                else if (cyc - last != CLK_DIV) bad_gap++;
                last = cyc;
                if (cpu_reset) n_rst++;
            end
            if (!cpu_reset) break;
        end
        chk("first_tick_cycle", 32'(first), 32'd1);
        chk("reset_ticks", 32'(n_rst), 32'(RST_TICKS));
        chk("reset_release_cycle", 32'(cyc), 32'(1 + CLK_DIV * (RST_TICKS - 1) + 1));
        chk("tick_spacing_errors", 32'(bad_gap), 32'd0);
        chk("cpu_di_after_reset", 32'(cpu_di), 32'hFF);
        repeat (CLK_DIV - 1) @(negedge clk25);
        prev_a = 16'h0000; prev_w = 1'b0; prev_d = 8'h00;
    endtask

    // At the completion tick of the previous access: check it, issue the next one,
    // walk through its wait ticks and stop at its completion tick
    task automatic step(input logic [15:0] a, input logic w, input logic [7:0] d,
                        input logic [31:0] dout);
        int s, nw;
        logic [3:0] exp_cs, exp_we;
        logic [7:0] exp_di;
        logic       exp_err;
        s       = ref_slave(prev_a);
        exp_cs  = (s >= 0) ? (4'b0001 << s) : 4'b0000;
        exp_we  = (s >= 0 && prev_w && ref_ro[(s >= 0) ? s : 0] == 0) ? exp_cs : 4'b0000;
        exp_err = (s < 0) || (prev_w && ref_ro[(s >= 0) ? s : 0] == 1);
        exp_di  = (s >= 0) ? slv_dout[8*s +: 8] : 8'hFF;
        chk("acc_cpu_rdy", 32'(cpu_rdy), 32'd1);
        chk("acc_bus_ab",  32'(bus_ab),  32'(prev_a));
        chk("acc_bus_do",  32'(bus_do),  32'(prev_d));
        chk("acc_slv_cs",  32'(slv_cs),  32'(exp_cs));
        chk("acc_slv_en",  32'(slv_en),  32'(s >= 0));
        chk("acc_bus_we",  32'(bus_we),  32'(exp_we));
        chk("acc_bus_err", 32'(bus_err), 32'(exp_err));
        cpu_ab = a; cpu_we = w; cpu_do = d;
        @(posedge clk25);
        #1;
        chk("acc_cpu_di",     32'(cpu_di),  32'(exp_di));
        chk("err_pulse_once", 32'(bus_err), 32'd0);
        chk("en_pulse_once",  32'(slv_en),  32'd0);
        slv_dout = dout;
        prev_a = a; prev_w = w; prev_d = d;
        s  = ref_slave(a);
        nw = (s >= 0) ? ref_wait[s] : 0;
        for (int k = 0; k < nw; k++) begin
            repeat (CLK_DIV) @(negedge clk25);
            chk("wait_cpu_rdy", 32'(cpu_rdy), 32'd0);
            chk("wait_slv_en",  32'(slv_en),  32'd0);
            chk("wait_bus_err", 32'(bus_err), 32'd0);
        end
        repeat (CLK_DIV) @(negedge clk25);
    endtask

    initial begin
        logic [15:0] ra;
        int          region;
        rst_n = 1'b0; cpu_ab = 16'h0000; cpu_do = 8'h00; cpu_we = 1'b0;
        slv_dout = 32'h0;
        repeat (3) @(negedge clk25);
        check_reset_values();
        slv_dout = $urandom;
        reset_release_and_sync();

        // Directed accesses
        step(16'h0005, 1'b0, 8'h00, 32'hA1B2C33C);
        step(16'hFF00, 1'b0, 8'h00, 32'h5E6F7A8B);
        step(16'hFFFC, 1'b1, 8'hAA, $urandom);
        step(16'hA000, 1'b0, 8'h00, $urandom);
        step(16'h0100, 1'b1, 8'h55, $urandom);
        step(16'hE123, 1'b1, 8'h12, $urandom);
        step(16'hD011, 1'b0, 8'h00, $urandom);

        // Randomized accesses across every region
        for (int n = 0; n < 40; n++) begin
            region = $urandom_range(0, 5);
            case (region)
                0:       ra = 16'($urandom_range(0, 16'h1FFF));
                1:       ra = 16'h D010 + 16'($urandom_range(0, 3));
                2:       ra = 16'hE000 + 16'($urandom_range(0, 16'h0FFF));
                3:       ra = 16'hFF00 + 16'($urandom_range(0, 16'h00FF));
                4:       ra = 16'h2000 + 16'($urandom_range(0, 16'hAFFF));
                default: ra = 16'($urandom);
            endcase
            step(ra, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
        end
        step(16'h0010, 1'b0, 8'h00, 32'h5A5A5A5A);

        // Reset in the middle of a wait-state access
        cpu_ab = 16'hFF00; cpu_we = 1'b0;
        @(posedge clk25);
        repeat (30) @(negedge clk25);
        chk("midwait_cpu_rdy", 32'(cpu_rdy), 32'd0);
        chk("midwait_bus_ab",  32'(bus_ab),  32'hFF00);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (4) @(negedge clk25);
        reset_release_and_sync();
        step(16'h0005, 1'b0, 8'h00, 32'h0000003C);
        step(16'hFF80, 1'b0, 8'h00, 32'h77000000);
        step(16'h0000, 1'b0, 8'h00, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time guard so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sys_bus_ctrl.md
# sys_bus_ctrl

Parametrised CPU-side bus controller for the 6502 system: clock-enable generation, power-up reset sequencing, registered address/data latching, N-way table-driven chip-select decode with read mux, and per-slave wait states and write protection. It sits between the `cpu` core and the memory-mapped slaves (RAM, ROMs, UART), replacing the fixed divider, reset counter and hard-coded decode in the top level.

## Interface
- `CLK_DIV`, 25, clk25 cycles per CPU tick (≥2)
- `RST_TICKS`, 63, ticks `cpu_reset` is held after `rst_n` release (1..255)
- `NUM_SLV`, 4, number of decoded slaves (1..8)
- `SLV_BASE`, Apple-1 map, NUM_SLV×16 flat; slave i matches when `(bus_ab & MASK[i]) == BASE[i]`
- `SLV_MASK`, Apple-1 map, NUM_SLV×16 flat
- `SLV_WAIT`, 0, NUM_SLV×4 flat; extra ticks per access to slave i (0..15)
- `SLV_RO`, 0, NUM_SLV bits; 1 = writes blocked
- `OPEN_BUS`, 8'hFF, read data when nothing is selected
---
- `clk25` in 1: master clock
- `rst_n` in 1: asynchronous, active-low reset
- `cpu_ab` in 16, `cpu_do` in 8, `cpu_we` in 1: CPU bus outputs
- `cpu_rdy` out 1: CPU RDY / clock enable
- `cpu_reset` out 1: active-high CPU reset
- `cpu_di` out 8: registered read data to the CPU
- `bus_ab` out 16, `bus_do` out 8: latched bus to slaves
- `bus_we` out NUM_SLV: per-slave write enable (selected, latched we, not RO)
- `slv_cs` out NUM_SLV: one-hot chip selects
- `slv_en` out 1: one-clk25 access strobe (`tick & |slv_cs`)
- `slv_dout` in NUM_SLV×8: slave read data
- `bus_err` out 1: one-cycle pulse on unmapped access or RO write

## Operation
- Divider counts 0..CLK_DIV-1 and wraps. `tick` is a registered pulse when count==0, one clk25 cycle every CLK_DIV.
- FSM states:
  - RESET: `cpu_reset`=1, `cpu_rdy`=`tick`, reset counter increments per tick; at RST_TICKS → RUN and `cpu_reset`←0 on that tick.
  - RUN: `cpu_rdy`=`tick`. On a `cpu_rdy` edge latch `bus_ab`/`bus_do`/we. If the new address selects slave i with WAIT[i]>0 → WAIT with wcnt=WAIT[i].
  - WAIT: `cpu_rdy`=0. Each tick decrements wcnt; the tick where wcnt reaches 0 returns to RUN. The next tick asserts `cpu_rdy`.
- Decode is combinational from `bus_ab`. On overlapping matches the lowest index wins, so `slv_cs` is always one-hot or zero.
- `cpu_di` is captured on every tick from `slv_dout[sel]`, or OPEN_BUS when nothing is selected.
- RO write: `bus_we[i]` stays 0 and `bus_err` pulses on the access tick.
- Unmapped read or write: `bus_err` pulses and the read returns OPEN_BUS.
- `rst_n` low at any time, including mid-WAIT: all state clears immediately and the FSM returns to RESET.

## Timing
- Reset values:
  - `cpu_reset`=1; `cpu_rdy`=0; `cpu_di`=OPEN_BUS.
  - `bus_ab`=0, `bus_do`=0, `bus_we`=0, `slv_cs`=0, `slv_en`=0, `bus_err`=0.
  - Divider=0, FSM=RESET.
- First tick occurs at clk25 edge 1 after `rst_n` release. `cpu_reset` falls RST_TICKS ticks later.
- Zero-wait access: address latched at tick T, `cpu_di` valid after tick T+1, so one CPU cycle per access.
- W-wait access: tick period unchanged; W ticks are suppressed. Next `cpu_rdy` at tick T+1+W.
- `slv_en` asserts in the same clk25 cycle as `tick` and is never asserted during RESET.

## Structure
- Package `sys_bus_pkg`:
  - FSM state enum {RESET, RUN, WAIT}
  - `WAIT_W`=4
  - Apple-1 map constants: RAM 0000/E000; UART D010/FFFC; BASIC E000/F000; WOZMON FF00/FF00
  - Default flat `SLV_BASE`/`SLV_MASK` built from those constants
- Sub-module `clken_gen` holds the divider and `tick` register. Decode, FSM and latches stay in the parent.

## Test plan
- Reset with defaults: `cpu_reset` high for 63 ticks (1575 clk25 cycles), then low. `cpu_rdy` pulses every 25 cycles.
- Read 0x0005 (RAM, slv 0), `slv_dout[0]`=8'h3C: `slv_cs`=4'b0001, `cpu_di`=8'h3C after the next tick.
- `SLV_WAIT[3]`=2, read 0xFF00: two ticks with `cpu_rdy`=0, then `cpu_rdy`; `cpu_di`=ROM data.
- `SLV_RO[3]`=1, write 8'hAA to 0xFFFC: `bus_we`=0 and `bus_err` pulses once.
- Read 0xA000 (unmapped): `cpu_di`=8'hFF and `bus_err` pulses once.
- `rst_n` low mid-WAIT: all outputs return to reset values asynchronously, and the full 63-tick reset sequence repeats.
